test_card_checker: RTL and testbench
====================================

TEST_CARD_CHECKER -- requirements
Module: test_card_checker

Interface
REQ-001 Parameter H_RES, default 640: active pixels per line; band width HW = H_RES>>3.
REQ-002 Parameter V_RES, default 480: active lines per frame; expected pixels per frame = H_RES*V_RES.
REQ-003 Parameter TOL, default 0: allowed absolute difference per colour channel.
REQ-004 Parameter LOCK_FRAMES, default 2: consecutive passing frames required for lock (range 1..15).
REQ-005 i_pix_clk  in  1  pixel clock; the only clock.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_frame  in  1  one-cycle pulse marking the start of a frame.
REQ-008 i_de  in  1  data enable; the pixel is valid when high.
REQ-009 i_x  in  16 signed  horizontal coordinate of the current pixel.
REQ-010 i_red, i_green, i_blue  in  8 each  received pixel colour.
REQ-011 o_frame_done  out  1  one-cycle pulse when frame results are published.
REQ-012 o_err_count  out  24  mismatching pixels in the last frame, saturating at 0xFFFFFF.
REQ-013 o_pix_count  out  24  valid pixels in the last frame, saturating at 0xFFFFFF.
REQ-014 o_first_err_x  out  16 signed  i_x of the first mismatch in the last frame; -1 if there was none.
REQ-015 o_pass  out  1  last frame had zero errors and pix_count = H_RES*V_RES.
REQ-016 o_locked  out  1  at least LOCK_FRAMES consecutive passing frames.

Function
REQ-017 Expected colour by band k = i_x/HW, for 0 <= i_x < 8*HW, as R,G,B:
- k0: FF,00,00
- k1: FF,FF,00
- k2: 00,FF,00
- k3: 00,FF,FF
- k4: 00,00,FF
- k5: FF,00,FF
- k6: 3F,3F,3F
- k7: 80,80,80
REQ-018 For i_x < 0 or i_x >= 8*HW, the expected colour is 00,00,00.
REQ-019 A pixel mismatches when any channel has |received - expected| > TOL; differences are computed unsigned with 9-bit width.
REQ-020 Pipeline:
- stage 1 registers i_de, i_frame, i_x, the colour and the expected colour;
- stage 2 compares and accumulates.
REQ-021 Pixels with i_de low are neither counted nor compared.
REQ-022 When the frame marker reaches stage 2, the accumulators are published to the outputs and cleared, and o_frame_done pulses.
- o_frame_done is therefore high exactly 2 cycles after the i_frame input cycle.
REQ-023 If i_frame and i_de are high in the same cycle, that pixel belongs to the new frame.
REQ-024 The first mismatch of a frame latches its stage-1 i_x; later mismatches leave it unchanged.
REQ-025 Both counters saturate and never wrap.
REQ-026 FSM states IDLE, CHECK, LOCKED:
- IDLE -> CHECK on the first frame marker; no o_frame_done pulse is issued, because the partial frame is discarded.
- CHECK: each published pass increments pass_run; each fail clears it.
- CHECK -> LOCKED when pass_run reaches LOCK_FRAMES.
- LOCKED -> CHECK on a failing frame.
REQ-027 o_locked is high only in LOCKED and updates in the same cycle as o_frame_done.
REQ-028 Published outputs hold their values between o_frame_done pulses.

Reset
REQ-029 Reset returns the FSM to IDLE and clears both pipeline stages and all accumulators.
REQ-030 Reset values:
- o_frame_done, o_pass, o_locked = 0;
- o_err_count and o_pix_count = 0;
- o_first_err_x = -1.
REQ-031 Reset asserted mid-frame discards in-flight pixels and any pending frame marker; no o_frame_done pulse follows.

Structure
REQ-032 Package test_card_pkg holds:
- the eight band colour constants;
- the FSM state enum;
- the band-width function H_RES>>3.
REQ-033 A combinational sub-module tc_band_colour maps i_x and H_RES to the expected RGB.
- The checker instantiates it once.

Verification
REQ-034 Default parameters; reset; first frame ignored; then one ideal 640x480 frame -> o_frame_done 2 cycles after i_frame, o_err_count=0, o_pix_count=307200, o_pass=1, o_first_err_x=-1.
REQ-035 Two further ideal frames -> o_locked=1 at the second o_frame_done after the first passing frame.
- Then a frame with pixel x=200 set to 00,00,00 -> o_err_count=1, o_first_err_x=200, o_pass=0, o_locked=0.
REQ-036 TOL=2; band k6 pixels sent as 41,3D,3F -> no errors.
- The same pixels sent as 42,3F,3F -> one error per pixel.
REQ-037 Frame missing its last line (306560 pixels), no colour errors -> o_err_count=0, o_pix_count=306560, o_pass=0.
REQ-038 i_frame coincident with a valid pixel at x=0 -> that pixel is counted in the new frame, not the previous one.
REQ-039 i_rst pulsed mid-frame -> no o_frame_done pulse, outputs return to reset values, and the next full frame is ignored (IDLE).

Source files
------------

// File: rtl/test_card_pkg.sv
// Shared constants and types for the colour-bar test card checker.
package test_card_pkg;

  localparam logic [23:0] BAND_K0 = 24'hFF0000;
  localparam logic [23:0] BAND_K1 = 24'hFFFF00;
  localparam logic [23:0] BAND_K2 = 24'h00FF00;
  localparam logic [23:0] BAND_K3 = 24'h00FFFF;
  localparam logic [23:0] BAND_K4 = 24'h0000FF;
  localparam logic [23:0] BAND_K5 = 24'hFF00FF;
  localparam logic [23:0] BAND_K6 = 24'h3F3F3F;
  localparam logic [23:0] BAND_K7 = 24'h808080;
  localparam logic [23:0] BAND_OFF = 24'h000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } tc_state_e;

  function automatic int band_width(input int h_res);
    return h_res >> 3;
  endfunction

endpackage

// File: rtl/tc_band_colour.sv
// Combinational map from a horizontal coordinate to the expected bar colour.
module tc_band_colour import test_card_pkg::*; #(
  parameter int H_RES = 640
) (
  input  logic signed [15:0] x,
  output logic [23:0]        rgb
);

  localparam int HW   = band_width(H_RES);
  localparam int SPAN = 8 * HW;

  int         xi;
  logic [2:0] band;

  assign xi = int'(x);

  // Band index is the number of band boundaries at or left of x.
  always_comb begin
    band = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xi >= k * HW) band = 3'(k);
    end
    case (band)
      3'd0:    rgb = BAND_K0;
      3'd1:    rgb = BAND_K1;
      3'd2:    rgb = BAND_K2;
      3'd3:    rgb = BAND_K3;
      3'd4:    rgb = BAND_K4;
      3'd5:    rgb = BAND_K5;
      3'd6:    rgb = BAND_K6;
      default: rgb = BAND_K7;
    endcase
    if (xi < 0 || xi >= SPAN) rgb = BAND_OFF;
  end

endmodule

// File: rtl/test_card_checker.sv
// Two-stage checker comparing received video against the colour-bar test card
// and publishing per-frame error statistics plus a lock indication.
module test_card_checker import test_card_pkg::*; #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int TOL         = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               i_pix_clk,
  input  logic               i_rst,
  input  logic               i_frame,
  input  logic               i_de,
  input  logic signed [15:0] i_x,
  input  logic [7:0]         i_red,
  input  logic [7:0]         i_green,
  input  logic [7:0]         i_blue,
  output logic               o_frame_done,
  output logic [23:0]        o_err_count,
  output logic [23:0]        o_pix_count,
  output logic signed [15:0] o_first_err_x,
  output logic               o_pass,
  output logic               o_locked,
  output tc_state_e          o_dbg_state
);

  localparam logic [23:0] FRAME_PIXELS = 24'(H_RES * V_RES);
  localparam logic [23:0] CNT_MAX      = 24'hFFFFFF;
  localparam logic [8:0]  TOL9         = 9'(TOL);
  localparam logic [3:0]  LOCK_N       = 4'(LOCK_FRAMES);

  // i_de qualifies each pixel; there is no backpressure, every cycle is accepted.
  logic [23:0] exp_rgb;

  tc_band_colour #(.H_RES(H_RES)) u_band (
    .x   (i_x),
    .rgb (exp_rgb)
  );

  logic               s1_de, s1_frame;
  logic signed [15:0] s1_x;
  logic [23:0]        s1_rgb, s1_exp;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      s1_de    <= 1'b0;
      s1_frame <= 1'b0;
      s1_x     <= '0;
      s1_rgb   <= '0;
      s1_exp   <= '0;
    end else begin
      s1_de    <= i_de;
      s1_frame <= i_frame;
      s1_x     <= i_x;
      s1_rgb   <= {i_red, i_green, i_blue};
      s1_exp   <= exp_rgb;
    end
  end

  function automatic logic chan_bad(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d > TOL9;
  endfunction

  logic mismatch;
  assign mismatch = s1_de && (chan_bad(s1_rgb[23:16], s1_exp[23:16]) ||
                              chan_bad(s1_rgb[15:8],  s1_exp[15:8])  ||
                              chan_bad(s1_rgb[7:0],   s1_exp[7:0]));

  logic [23:0]        acc_err, acc_pix;
  logic signed [15:0] acc_first_x;
  logic               acc_has_err;

  // A pixel arriving with the frame marker opens the new frame's accumulators.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      acc_err     <= '0;
      acc_pix     <= '0;
      acc_first_x <= '1;
      acc_has_err <= 1'b0;
    end else if (s1_frame) begin
      acc_pix     <= s1_de ? 24'd1 : 24'd0;
      acc_err     <= mismatch ? 24'd1 : 24'd0;
      acc_has_err <= mismatch;
      acc_first_x <= mismatch ? s1_x : '1;
    end else begin
      if (s1_de && acc_pix != CNT_MAX) acc_pix <= acc_pix + 24'd1;
      if (mismatch && acc_err != CNT_MAX) acc_err <= acc_err + 24'd1;
      if (mismatch && !acc_has_err) begin
        acc_has_err <= 1'b1;
        acc_first_x <= s1_x;
      end
    end
  end

  tc_state_e  state, state_n;
  logic [3:0] pass_run, run_n;
  logic       frame_pass, publish;

  assign frame_pass = (acc_err == 24'd0) && (acc_pix == FRAME_PIXELS);
  assign publish    = s1_frame && (state != ST_IDLE);

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      pass_run <= '0;
    end else begin
      state    <= state_n;
      pass_run <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    run_n   = pass_run;
    case (state)
      ST_IDLE: begin
        if (s1_frame) begin
          state_n = ST_CHECK;
          run_n   = '0;
        end
      end
      ST_CHECK: begin
        if (s1_frame) begin
          if (frame_pass) begin
            run_n = pass_run + 4'd1;
            if (run_n >= LOCK_N) state_n = ST_LOCKED;
          end else begin
            run_n = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (s1_frame && !frame_pass) begin
          state_n = ST_CHECK;
          run_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        run_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_frame_done  <= 1'b0;
      o_err_count   <= '0;
      o_pix_count   <= '0;
      o_first_err_x <= '1;
      o_pass        <= 1'b0;
    end else begin
      o_frame_done <= publish;
      if (publish) begin
        o_err_count   <= acc_err;
        o_pix_count   <= acc_pix;
        o_first_err_x <= acc_first_x;
        o_pass        <= frame_pass;
      end
    end
  end

  assign o_locked    = (state == ST_LOCKED);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_test_card_checker.sv
// Randomized self-checking bench for test_card_checker using a frame-level model.
module tb_test_card_checker;
  import test_card_pkg::*;

  localparam int H_RES       = 64;
  localparam int V_RES       = 4;
  localparam int TOL         = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int HW          = H_RES / 8;

  localparam logic [23:0] BAND_TAB [8] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                                           24'h0000FF, 24'hFF00FF, 24'h3F3F3F, 24'h808080};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               frame = 1'b0, de = 1'b0;
  logic signed [15:0] x = '0;
  logic [7:0]         red = '0, green = '0, blue = '0;
  logic               done, pass, locked;
  logic [23:0]        err_cnt, pix_cnt;
  logic signed [15:0] first_x;
  tc_state_e          dbg;

  test_card_checker #(
    .H_RES(H_RES), .V_RES(V_RES), .TOL(TOL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .i_pix_clk     (clk),
    .i_rst         (rst),
    .i_frame       (frame),
    .i_de          (de),
    .i_x           (x),
    .i_red         (red),
    .i_green       (green),
    .i_blue        (blue),
    .o_frame_done  (done),
    .o_err_count   (err_cnt),
    .o_pix_count   (pix_cnt),
    .o_first_err_x (first_x),
    .o_pass        (pass),
    .o_locked      (locked),
    .o_dbg_state   (dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model: current-frame statistics and lock history
  int  m_err = 0, m_pix = 0, m_first_x = -1, m_run = 0;
  bit  m_idle = 1'b1;
  logic [63:0] exp_q[$];

  function automatic logic [23:0] model_colour(input int xv);
    if (xv < 0 || xv >= 8 * HW) return 24'h000000;
    return BAND_TAB[xv / HW];
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit model_bad(input int xv, input int rv, input int gv, input int bv);
    logic [23:0] e;
    e = model_colour(xv);
    return absdiff(rv, int'(e[23:16])) > TOL || absdiff(gv, int'(e[15:8])) > TOL ||
           absdiff(bv, int'(e[7:0])) > TOL;
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one input cycle, model updated for every valid pixel
  task automatic drive(input bit f, input bit d, input int xv, input int rv, input int gv, input int bv);
    frame = f;
    de    = d;
    x     = 16'(xv);
    red   = 8'(rv);
    green = 8'(gv);
    blue  = 8'(bv);
    if (d) begin
      m_pix++;
      if (model_bad(xv, rv, gv, bv)) begin
        if (m_err == 0) m_first_x = xv;
        m_err++;
      end
    end
    tick();
  endtask

  // mode 0 ideal, 1 one black pixel at x=20, 2 band 6 within tolerance, 3 band 6 outside, 4 random
  task automatic send_frame(input int lines, input int mode, input bit skip_first);
    for (int ln = 0; ln < lines; ln++) begin
      for (int px = 0; px < H_RES; px++) begin
        logic [23:0] c;
        int rv, gv, bv;
        bit d;
        if (!(skip_first && ln == 0 && px == 0)) begin
          c  = model_colour(px);
          rv = int'(c[23:16]);
          gv = int'(c[15:8]);
          bv = int'(c[7:0]);
          d  = 1'b1;
          if (mode == 1 && ln == 1 && px == 20) begin
            rv = 0; gv = 0; bv = 0;
          end
          if ((mode == 2 || mode == 3) && px >= 6 * HW && px < 7 * HW) begin
            rv = (mode == 2) ? 'h41 : 'h42;
            gv = (mode == 2) ? 'h3D : 'h3F;
            bv = 'h3F;
          end
          if (mode == 4) begin
            d = ($urandom_range(0, 15) != 0);
            if (!d) begin
              rv = int'($urandom_range(0, 255)); gv = int'($urandom_range(0, 255));
              bv = int'($urandom_range(0, 255));
            end else if ($urandom_range(0, 3) == 0) begin
              rv = clamp8(rv + int'($urandom_range(0, 8)) - 4);
              gv = clamp8(gv + int'($urandom_range(0, 8)) - 4);
              bv = clamp8(bv + int'($urandom_range(0, 8)) - 4);
            end
          end
          drive(1'b0, d, px, rv, gv, bv);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (mode == 4) begin
          int xb;
          xb = ($urandom_range(0, 1) == 0) ? -int'($urandom_range(1, 30)) : H_RES + int'($urandom_range(0, 30));
          drive(1'b0, 1'($urandom_range(0, 1)), xb, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end else begin
          drive(1'b0, 1'b0, -3, 255, 255, 255);
        end
      end
    end
  endtask

  // frame marker: closes the modelled frame and checks what the DUT publishes
  task automatic frame_marker(input bit with_pix, input int rv, input int gv, input int bv);
    bit exp_done, exp_pass, exp_locked;
    logic [63:0] e;
    exp_done = !m_idle;
    exp_pass = (m_err == 0) && (m_pix == H_RES * V_RES);
    if (exp_done) begin
      exp_q.push_back({24'(m_err), 24'(m_pix), 16'(m_first_x)});
      m_run = exp_pass ? m_run + 1 : 0;
    end
    exp_locked = (m_run >= LOCK_FRAMES);
    m_idle = 1'b0; m_err = 0; m_pix = 0; m_first_x = -1;
    drive(1'b1, with_pix, 0, rv, gv, bv);
    n_vec++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b want 0", done); end
    drive(1'b0, 1'b0, -7, 0, 0, 0);
    n_vec++;
    if (done !== exp_done) begin n_bad++; $display("FAIL done_latency: got %b want %b", done, exp_done); end
    n_vec++;
    if (locked !== exp_locked) begin n_bad++; $display("FAIL locked: got %b want %b", locked, exp_locked); end
    if (exp_done) begin
      e = exp_q.pop_front();
      n_vec++;
      if (err_cnt !== e[63:40]) begin n_bad++; $display("FAIL err_count: got %0d want %0d", err_cnt, e[63:40]); end
      n_vec++;
      if (pix_cnt !== e[39:16]) begin n_bad++; $display("FAIL pix_count: got %0d want %0d", pix_cnt, e[39:16]); end
      n_vec++;
      if (first_x !== e[15:0]) begin n_bad++; $display("FAIL first_err_x: got %0d want %0d", first_x, $signed(e[15:0])); end
      n_vec++;
      if (pass !== exp_pass) begin n_bad++; $display("FAIL pass: got %b want %b", pass, exp_pass); end
    end
    drive(1'b0, 1'b0, -7, 0, 0, 0);
    n_vec++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (err_cnt !== 24'd0) begin n_bad++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    n_vec++; if (pix_cnt !== 24'd0) begin n_bad++; $display("FAIL rst_pix: got %0d want 0", pix_cnt); end
    n_vec++; if (first_x !== -16'sd1) begin n_bad++; $display("FAIL rst_first_x: got %0d want -1", first_x); end
    n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL rst_pass: got %b want 0", pass); end
    n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    n_vec++; if (dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dbg, ST_IDLE); end
  endtask

  task automatic test_first_frame_ignored();
    for (int i = 30; i < 40; i++) drive(1'b0, 1'b1, i, 0, 0, 0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (pix_cnt !== 24'd0) begin n_bad++; $display("FAIL ignored_pix: got %0d want 0", pix_cnt); end
    send_frame(V_RES, 0, 1'b0);
  endtask

  task automatic test_ideal_frames();
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (pix_cnt !== 24'(H_RES * V_RES)) begin n_bad++; $display("FAIL ideal_pix: got %0d want %0d", pix_cnt, H_RES * V_RES); end
    n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL ideal_pass: got %b want 1", pass); end
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_two: got %b want 1", locked); end
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
  endtask

  task automatic test_single_error();
    send_frame(V_RES, 1, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (err_cnt !== 24'd1) begin n_bad++; $display("FAIL single_err: got %0d want 1", err_cnt); end
    n_vec++; if (first_x !== 16'sd20) begin n_bad++; $display("FAIL single_first_x: got %0d want 20", first_x); end
    n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL single_unlock: got %b want 0", locked); end
  endtask

  task automatic test_coincident();
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b1, 0, 0, 0);
    n_vec++; if (pix_cnt !== 24'(H_RES * V_RES)) begin n_bad++; $display("FAIL coin_prev_pix: got %0d want %0d", pix_cnt, H_RES * V_RES); end
    send_frame(V_RES, 0, 1'b1);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (err_cnt !== 24'd1) begin n_bad++; $display("FAIL coin_err: got %0d want 1", err_cnt); end
    n_vec++; if (first_x !== 16'sd0) begin n_bad++; $display("FAIL coin_first_x: got %0d want 0", first_x); end
  endtask

  task automatic test_tolerance();
    send_frame(V_RES, 2, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (err_cnt !== 24'd0) begin n_bad++; $display("FAIL tol_inside: got %0d want 0", err_cnt); end
    send_frame(V_RES, 3, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (err_cnt !== 24'(V_RES * HW)) begin n_bad++; $display("FAIL tol_outside: got %0d want %0d", err_cnt, V_RES * HW); end
  endtask

  task automatic test_short_frame();
    send_frame(V_RES - 1, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (pix_cnt !== 24'(H_RES * (V_RES - 1))) begin n_bad++; $display("FAIL short_pix: got %0d want %0d", pix_cnt, H_RES * (V_RES - 1)); end
    n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL short_pass: got %b want 0", pass); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      send_frame(V_RES, 4, 1'b0);
      frame_marker(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0, 0);
    end
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(2, 0, 1'b0);
    drive(1'b1, 1'b1, 0, 255, 0, 0);
    rst = 1'b1; frame = 1'b0; de = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_idle = 1'b1; m_run = 0; m_err = 0; m_pix = 0; m_first_x = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    end
    n_vec++; if (err_cnt !== 24'd0) begin n_bad++; $display("FAIL midrst_err: got %0d want 0", err_cnt); end
    n_vec++; if (pix_cnt !== 24'd0) begin n_bad++; $display("FAIL midrst_pix: got %0d want 0", pix_cnt); end
    n_vec++; if (first_x !== -16'sd1) begin n_bad++; $display("FAIL midrst_first_x: got %0d want -1", first_x); end
    n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked: got %b want 0", locked); end
    n_vec++; if (dbg !== ST_IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d want %0d", dbg, ST_IDLE); end
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    send_frame(V_RES, 0, 1'b0);
    frame_marker(1'b0, 0, 0, 0);
    n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL recover_pass: got %b want 1", pass); end
  endtask

  initial begin
    test_reset();
    test_first_frame_ignored();
    test_ideal_frames();
    test_single_error();
    test_coincident();
    test_tolerance();
    test_short_frame();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
